// File: rtl/tdc_therm_accum.sv
// Thermometer-code ones-counter with windowed avg/min/max/bubble reporting.
// Build option: define TDC_ROUND_EN for a round-half-up average (default truncates).
module tdc_therm_accum #(
  parameter int N_DELAY  = 32,
  parameter int ACC_LOG2 = 4,
  localparam int CW = $clog2(N_DELAY + 1),
  localparam int SW = CW + ACC_LOG2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_DELAY-1:0] therm_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      out_avg,
  output logic [CW-1:0]      out_min,
  output logic [CW-1:0]      out_max,
  output logic               out_bubble
);

  // state | meaning
  // ACCUM | accepting samples until the window is full
  // DRAIN | pipeline flushing, in_ready low, timer counts down to load
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  state_t              state;
  logic [ACC_LOG2-1:0] smp_cnt;
  logic [1:0]          drain_tmr;
  logic                s1_vld;
  logic [CW-1:0]       s1_cnt;
  logic                s1_bub;
  logic [SW-1:0]       sum;
  logic [CW-1:0]       min_q;
  logic [CW-1:0]       max_q;
  logic                bub_acc;
  logic [CW-1:0]       pop_cnt;
  logic                bub_det;
  logic [SW-1:0]       sum_adj;
  logic                accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      pop_cnt = pop_cnt + CW'(therm_code[i]);
    end
  end

  // A set bit sitting directly above a clear bit marks a non-thermometer code.
  assign bub_det = |(therm_code[N_DELAY-1:1] & ~therm_code[N_DELAY-2:0]);

`ifdef TDC_ROUND_EN
  assign sum_adj = sum + SW'(1 << (ACC_LOG2 - 1));
`else
  assign sum_adj = sum;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= ACCUM;
      smp_cnt    <= '0;
      drain_tmr  <= '0;
      s1_vld     <= 1'b0;
      s1_cnt     <= '0;
      s1_bub     <= 1'b0;
      sum        <= '0;
      min_q      <= '1;
      max_q      <= '0;
      bub_acc    <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_avg    <= '0;
      out_min    <= '0;
      out_max    <= '0;
      out_bubble <= 1'b0;
    end else if (clr) begin
      state     <= ACCUM;
      smp_cnt   <= '0;
      drain_tmr <= '0;
      s1_vld    <= 1'b0;
      sum       <= '0;
      min_q     <= '1;
      max_q     <= '0;
      bub_acc   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_cnt <= pop_cnt;
        s1_bub <= bub_det;
      end
      if (s1_vld) begin
        sum     <= sum + SW'(s1_cnt);
        bub_acc <= bub_acc | s1_bub;
        if (s1_cnt < min_q) min_q <= s1_cnt;
        if (s1_cnt > max_q) max_q <= s1_cnt;
      end
      case (state)
        ACCUM: begin
          if (accept) begin
            smp_cnt <= smp_cnt + 1'b1;
            if (smp_cnt == '1) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              drain_tmr <= 2'd2;
            end
          end
        end
        DRAIN: begin
          if (drain_tmr == 2'd0) begin
            out_avg    <= sum_adj[SW-1:ACC_LOG2];
            out_min    <= min_q;
            out_max    <= max_q;
            out_bubble <= bub_acc;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            drain_tmr <= drain_tmr - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
            smp_cnt   <= '0;
            sum       <= '0;
            min_q     <= '1;
            max_q     <= '0;
            bub_acc   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_therm_accum.sv
// Directed bench for tdc_therm_accum with a window scoreboard.
module tb_tdc_therm_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] therm_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_avg;
  logic [5:0]  out_min;
  logic [5:0]  out_max;
  logic        out_bubble;

  tdc_therm_accum #(.N_DELAY(32), .ACC_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .therm_code(therm_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_avg(out_avg), .out_min(out_min), .out_max(out_max), .out_bubble(out_bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   avg;
    int   mn;
    int   mx;
    logic bub;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_n, m_sum, m_min, m_max;
  logic m_bub;
  time  acc_time;

  task automatic chk(input string tag, input int got, input int expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic model_clear();
    m_n = 0; m_sum = 0; m_min = 1000; m_max = 0; m_bub = 1'b0;
  endtask

  function automatic logic model_bubble(input logic [31:0] c);
    logic [63:0] t;
    t = (64'd1 << $countones(c)) - 64'd1;
    return c != t[31:0];
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [31:0] code);
    int g;
    int k;
    exp_t e;
    g = 0;
    in_valid = 1'b1;
    therm_code = code;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
    @(posedge clk);
    acc_time = $time;
    k = $countones(code);
    m_sum += k;
    if (k < m_min) m_min = k;
    if (k > m_max) m_max = k;
    m_bub = m_bub | model_bubble(code);
    m_n++;
    if (m_n == 16) begin
`ifdef TDC_ROUND_EN
      e.avg = (m_sum + 8) >> 4;
`else
      e.avg = m_sum >> 4;
`endif
      e.mn = m_min; e.mx = m_max; e.bub = m_bub;
      sbq.push_back(e);
      model_clear();
    end
    @(negedge clk);
  endtask

  task automatic wait_result();
    int g;
    g = 0;
    in_valid = 1'b0;
    while (!out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("out_valid_seen", int'(out_valid), 1);
    if (out_valid) begin
      chk("latency_edges", int'((($time - 5) - acc_time) / 10), 3);
      if (sbq.size() == 0) begin
        chk("scoreboard_nonempty", 0, 1);
      end else begin
        last_exp = sbq.pop_front();
        chk("out_avg", int'(out_avg), last_exp.avg);
        chk("out_min", int'(out_min), last_exp.mn);
        chk("out_max", int'(out_max), last_exp.mx);
        chk("out_bubble", int'(out_bubble), int'(last_exp.bub));
      end
    end
  endtask

  task automatic check_released();
    @(negedge clk);
    chk("post_hs_out_valid", int'(out_valid), 0);
    chk("post_hs_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_avg", int'(out_avg), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_min", int'(out_min), 0);
    chk("rst_out_max", int'(out_max), 0);
    chk("rst_out_bubble", int'(out_bubble), 0);

    // 16 x 0x0000FFFF, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(32'h0000FFFF);
    wait_result();
    check_released();

    // 8 x 0xFF then 8 x 0xFFF
    for (int i = 0; i < 16; i++) send(i < 8 ? 32'h000000FF : 32'h00000FFF);
    wait_result();
    check_released();

    // 8 x 0x1 then 8 x 0x3 : truncate vs round differ
    for (int i = 0; i < 16; i++) send(i < 8 ? 32'h00000001 : 32'h00000003);
    wait_result();
    check_released();

    // one bubbled code among fifteen clean ones
    for (int i = 0; i < 16; i++) send(i == 5 ? 32'h0000F0FF : 32'h000000FF);
    wait_result();
    check_released();

    // back-pressure: hold result for 5 cycles with ignored in_valid pulses
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(32'h00000007);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      therm_code = 32'hFFFFFFFF;
      @(negedge clk);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_avg", int'(out_avg), last_exp.avg);
      chk("hold_out_max", int'(out_max), last_exp.mx);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_released();

    // reset mid-window, then clr colliding with a sample
    for (int i = 0; i < 7; i++) send(32'h000000FF);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_avg", int'(out_avg), 0);
    chk("midrst_out_max", int'(out_max), 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    clr = 1'b1;
    in_valid = 1'b1;
    therm_code = 32'h00000000;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 16; i++) send(32'hFFFFFFFF);
    wait_result();
    check_released();

    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_therm_accum.md
Name: tdc_therm_accum

Overview:
- Downstream stage of the delay-line TDC capture register. Consumes N_DELAY-bit thermometer snapshots and converts each to a bubble-tolerant ones-count.
- Accumulates 2^ACC_LOG2 samples per window and reports the windowed average, minimum, maximum and a bubble flag through a valid/ready handshake.
- Replaces the raw 8-bit slice mux as the source of the chip's output byte.

Parameters:
- N_DELAY, 32, thermometer code width (number of delay taps).
- ACC_LOG2, 4, log2 of samples per window. Legal range 1..8.
- Derived CW = clog2(N_DELAY+1) (6 at default). Derived SW = CW + ACC_LOG2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-high (asserted when 1).
- clr  input  1  synchronous window abort.
- in_valid  input  1  therm_code valid.
- in_ready  output  1  block accepts a sample this cycle.
- therm_code  input  N_DELAY  delay-line snapshot.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- out_avg  output  CW  window average.
- out_min  output  CW  window minimum count.
- out_max  output  CW  window maximum count.
- out_bubble  output  1  a bubble was seen in any sample of the window.

Behaviour:
- Reset (rst_n=1, asynchronous):
  - state=ACCUM, sample counter=0, accumulator=0.
  - min register = all-ones; max register = 0.
  - out_valid=0; out_avg, out_min, out_max and out_bubble = 0.
  - in_ready=1 once rst_n is released.
- Accept: a sample is taken on a rising clk edge where in_valid && in_ready.
- Stage 1 (1 cycle after accept), registered:
  - cnt = popcount(therm_code), 0..N_DELAY.
  - bub = 1 if any bit i>0 is 1 while some bit j<i is 0 (not a pure thermometer code).
- Stage 2 (cycle after stage 1):
  - sum += cnt; min = min(min, cnt); max = max(max, cnt); bub_acc |= bub.
  - sum is SW bits wide and cannot overflow.
- State ACCUM:
  - in_ready=1 until 2^ACC_LOG2 samples have been accepted.
  - On the last accept, in_ready drops the next cycle and the FSM moves to DRAIN.
- State DRAIN:
  - in_ready=0; waits 2 cycles for stages 1 and 2 to flush.
  - Then loads the output registers and moves to DONE.
  - out_valid rises exactly 3 clk edges after the last accepting edge.
- Output values:
  - out_avg = sum >> ACC_LOG2 (truncate).
  - out_min and out_max taken from their registers.
  - out_bubble = bub_acc.
- State DONE:
  - out_valid=1 and outputs held stable while out_ready=0. in_ready=0.
  - On out_valid && out_ready: out_valid clears next cycle; sum, counter, min, max and bub_acc reinitialise; state returns to ACCUM with in_ready=1.
  - The output data registers keep their last values until the next load.
- Samples are never dropped while in_ready=1. in_valid is ignored when in_ready=0.
- clr=1 (any state):
  - Next cycle: pipeline contents discarded, accumulators reinitialised, out_valid=0, state=ACCUM.
  - clr has priority over a simultaneous accept (that sample is dropped) and over a simultaneous out_ready (the result is discarded).
- Reset mid-window or in DONE: all state returns to reset values immediately. No partial result is ever emitted.
- Boundaries:
  - All-zero code gives cnt=0.
  - All-ones code gives cnt=N_DELAY.
  - A window of all-ones codes gives out_avg=N_DELAY.

Optional Feature:
- Macro: TDC_ROUND_EN.
- Defined: out_avg = (sum + 2^(ACC_LOG2-1)) >> ACC_LOG2 (round half up). The result is at most N_DELAY, so no width growth.
- Undefined: truncating average as above.
- Every other behaviour is identical in both builds.

Test Plan:
- 16 samples of 0x0000FFFF, back-to-back in_valid, out_ready=1 -> out_avg=16, out_min=16, out_max=16, out_bubble=0; out_valid 3 edges after the 16th accept, for 1 cycle.
- 8 samples of 0x000000FF then 8 of 0x00000FFF -> sum=160, out_avg=10, out_min=8, out_max=12.
- 8 samples of 0x00000001 then 8 of 0x00000003 -> sum=24, out_avg=1 with TDC_ROUND_EN undefined, out_avg=2 with it defined.
- One sample of 0x0000F0FF among 15 samples of 0x000000FF -> that sample counts 12, out_max=12, out_bubble=1.
- Result ready with out_ready=0 for 5 cycles -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> next cycle out_valid=0, in_ready=1.
- rst_n pulse after 7 accepts, then clr in the same cycle as an 8th in_valid -> outputs at reset values, dropped sample not counted; a fresh 16-sample window of 0xFFFFFFFF gives out_avg=32.
